reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_sb.sv | 92 +++++++++
 tb/tb_reg_file_sb.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// Multi-port register file with per-register pending (scoreboard) bits,
// byte-enabled writes, write-first read bypass and an optional zero register.
module reg_file_sb #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NRD     = 2,
    parameter int ZERO_R0 = 1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [NRD*ADDR_W-1:0]   rR_i,
    output logic [NRD*DATA_W-1:0]   rD_o,
    output logic [NRD-1:0]          rBusy_o,
    input  logic                    WE_i,
    input  logic [ADDR_W-1:0]       wR_i,
    input  logic [DATA_W-1:0]       wD_i,
    input  logic [DATA_W/8-1:0]     wBE_i,
    input  logic                    set_i,
    input  logic [ADDR_W-1:0]       setR_i,
    output logic [ADDR_W:0]         pend_cnt_o
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int NBYTE = DATA_W/8;
    localparam logic [ADDR_W:0] CNT_ONE = 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [ADDR_W:0]   pend_cnt_q;

    logic              we_eff;
    logic              set_eff;
    logic              cnt_inc;
    logic              cnt_dec;
    logic [DATA_W-1:0] wr_merged;

    // Accesses to a hardwired r0 are dropped before they reach any state.
    assign we_eff  = WE_i  && !(ZERO_R0 != 0 && wR_i   == '0);
    assign set_eff = set_i && !(ZERO_R0 != 0 && setR_i == '0);

    assign cnt_inc = set_eff && !busy_q[setR_i];
    assign cnt_dec = we_eff && busy_q[wR_i] && !(set_eff && setR_i == wR_i);

    // Value the write target will hold after this edge; also the bypass value.
    always_comb begin
        wr_merged = mem_q[wR_i];
        for (int j = 0; j < NBYTE; j++) begin
            if (wBE_i[j]) wr_merged[j*8 +: 8] = wD_i[j*8 +: 8];
        end
    end

    // NOTE: the storage array is reset too, because reads must return zero
    // while reset is held and after it releases, not stale contents.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            busy_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            if (we_eff) begin
                mem_q[wR_i]  <= wr_merged;
                busy_q[wR_i] <= 1'b0;
            end
            // Later non-blocking assignment wins, so a same-address set overrides the clear.
            if (set_eff) busy_q[setR_i] <= 1'b1;

            if (cnt_inc && !cnt_dec)      pend_cnt_q <= pend_cnt_q + CNT_ONE;
            else if (cnt_dec && !cnt_inc) pend_cnt_q <= pend_cnt_q - CNT_ONE;
        end
    end

    assign pend_cnt_o = pend_cnt_q;

    always_comb begin
        rD_o    = '0;
        rBusy_o = '0;
        for (int k = 0; k < NRD; k++) begin
            if (!reset_i && !(ZERO_R0 != 0 && rR_i[k*ADDR_W +: ADDR_W] == '0)) begin
                if (we_eff && wR_i == rR_i[k*ADDR_W +: ADDR_W]) begin
                    rD_o[k*DATA_W +: DATA_W] = wr_merged;
                    // A write in flight retires the producer unless a new one issues now.
                    rBusy_o[k] = busy_q[rR_i[k*ADDR_W +: ADDR_W]]
                                 && set_eff && setR_i == rR_i[k*ADDR_W +: ADDR_W];
                end else begin
                    rD_o[k*DATA_W +: DATA_W] = mem_q[rR_i[k*ADDR_W +: ADDR_W]];
                    rBusy_o[k] = busy_q[rR_i[k*ADDR_W +: ADDR_W]];
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios plus randomized
// traffic compared against a behavioural array model of registers and pending bits.
module tb_reg_file_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic             clk_i = 1'b0;
    logic             reset_i;
    logic [NR*AW-1:0] rR_i;
    logic [NR*DW-1:0] rD_o;
    logic [NR-1:0]    rBusy_o;
    logic             WE_i;
    logic [AW-1:0]    wR_i;
    logic [DW-1:0]    wD_i;
    logic [DW/8-1:0]  wBE_i;
    logic             set_i;
    logic [AW-1:0]    setR_i;
    logic [AW:0]      pend_cnt_o;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] m_mem  [32];
    bit            m_busy [32];

    reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .ZERO_R0(1)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .rR_i(rR_i), .rD_o(rD_o), .rBusy_o(rBusy_o),
        .WE_i(WE_i), .wR_i(wR_i), .wD_i(wD_i), .wBE_i(wBE_i),
        .set_i(set_i), .setR_i(setR_i), .pend_cnt_o(pend_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- reference model ----------------
    function automatic logic [DW-1:0] m_merge(int a);
        logic [DW-1:0] v = m_mem[a];
        for (int j = 0; j < DW/8; j++)
            if (wBE_i[j]) v[j*8 +: 8] = wD_i[j*8 +: 8];
        return v;
    endfunction

    function automatic logic [DW-1:0] exp_rd(int a);
        if (a == 0) return '0;
        if (WE_i && int'(wR_i) == a) return m_merge(a);
        return m_mem[a];
    endfunction

    function automatic bit exp_busy(int a);
        if (a == 0) return 1'b0;
        if (WE_i && int'(wR_i) == a && !(set_i && int'(setR_i) == a)) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic int exp_cnt();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        if (WE_i && wR_i != 0) begin
            m_mem[wR_i]  = m_merge(int'(wR_i));
            m_busy[wR_i] = 1'b0;
        end
        if (set_i && setR_i != 0) m_busy[setR_i] = 1'b1;
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] wr, input logic [DW-1:0] wd,
                         input logic [3:0] be, input logic st, input logic [AW-1:0] sr,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        WE_i = we; wR_i = wr; wD_i = wd; wBE_i = be;
        set_i = st; setR_i = sr; rR_i = {a1, a0};
    endtask

    task automatic step();
        @(posedge clk_i);
        if (!reset_i) model_edge();
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_i = 1'b1;
        drive(1'b1, 5'd5, 32'hFFFF_FFFF, 4'hF, 1'b1, 5'd5, 5'd5, 5'd5);
        @(posedge clk_i); #1;
        checks++; if (rD_o !== '0) begin errors++; $display("FAIL rst_rd: got %h expected 0", rD_o); end
        checks++; if (rBusy_o !== '0) begin errors++; $display("FAIL rst_busy: got %b expected 0", rBusy_o); end
        checks++; if (pend_cnt_o !== '0) begin errors++; $display("FAIL rst_cnt: got %0d expected 0", pend_cnt_o); end
        @(negedge clk_i);
        reset_i = 1'b0;
        drive(1'b0, 5'd0, '0, 4'h0, 1'b0, 5'd0, 5'd5, 5'd5);
        #1;
        checks++; if (rD_o[31:0] !== 32'h0) begin errors++; $display("FAIL rst_discard_wr: got %h expected 0", rD_o[31:0]); end
        checks++; if (rBusy_o !== 2'b00) begin errors++; $display("FAIL rst_discard_set: got %b expected 00", rBusy_o); end
    endtask

    task automatic test_write_read();
        @(negedge clk_i);
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 4'hF, 1'b0, 5'd0, 5'd1, 5'd1);
        step();
        @(negedge clk_i);
        drive(1'b0, 5'd0, '0, 4'h0, 1'b0, 5'd0, 5'd5, 5'd5);
        #1;
        checks++; if (rD_o[31:0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_rd_p0: got %h expected deadbeef", rD_o[31:0]); end
        checks++; if (rD_o[63:32] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_rd_p1: got %h expected deadbeef", rD_o[63:32]); end
    endtask

    task automatic test_byte_enable();
        @(negedge clk_i);
        drive(1'b1, 5'd5, 32'h0000_AA00, 4'h2, 1'b0, 5'd0, 5'd5, 5'd6);
        #1;
        checks++; if (rD_o[31:0] !== 32'hDEAD_AAEF) begin errors++; $display("FAIL be_bypass: got %h expected deadaaef", rD_o[31:0]); end
        step();
        @(negedge clk_i);
        drive(1'b0, 5'd0, '0, 4'h0, 1'b0, 5'd0, 5'd6, 5'd5);
        #1;
        checks++; if (rD_o[63:32] !== 32'hDEAD_AAEF) begin errors++; $display("FAIL be_stored: got %h expected deadaaef", rD_o[63:32]); end
    endtask

    task automatic test_r0();
        @(negedge clk_i);
        drive(1'b1, 5'd0, 32'h1234_5678, 4'hF, 1'b1, 5'd0, 5'd0, 5'd0);
        #1;
        checks++; if (rD_o !== '0) begin errors++; $display("FAIL r0_bypass: got %h expected 0", rD_o); end
        checks++; if (rBusy_o !== 2'b00) begin errors++; $display("FAIL r0_busy: got %b expected 00", rBusy_o); end
        step();
        checks++; if (pend_cnt_o !== 6'd0) begin errors++; $display("FAIL r0_cnt: got %0d expected 0", pend_cnt_o); end
        @(negedge clk_i);
        drive(1'b0, 5'd0, '0, 4'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        #1;
        checks++; if (rD_o !== '0) begin errors++; $display("FAIL r0_stored: got %h expected 0", rD_o); end
    endtask

    task automatic test_busy();
        @(negedge clk_i);
        drive(1'b0, 5'd0, '0, 4'h0, 1'b1, 5'd7, 5'd7, 5'd7);
        #1;
        checks++; if (rBusy_o !== 2'b00) begin errors++; $display("FAIL busy_pre: got %b expected 00", rBusy_o); end
        step();
        checks++; if (pend_cnt_o !== 6'd1) begin errors++; $display("FAIL busy_cnt_set: got %0d expected 1", pend_cnt_o); end
        @(negedge clk_i);
        drive(1'b0, 5'd0, '0, 4'h0, 1'b0, 5'd0, 5'd7, 5'd7);
        #1;
        checks++; if (rBusy_o !== 2'b11) begin errors++; $display("FAIL busy_set: got %b expected 11", rBusy_o); end
        @(negedge clk_i);
        drive(1'b1, 5'd7, 32'h0BAD_F00D, 4'h1, 1'b0, 5'd0, 5'd7, 5'd7);
        #1;
        checks++; if (rBusy_o !== 2'b00) begin errors++; $display("FAIL busy_bypass: got %b expected 00", rBusy_o); end
        step();
        checks++; if (pend_cnt_o !== 6'd0) begin errors++; $display("FAIL busy_cnt_clr: got %0d expected 0", pend_cnt_o); end
        @(negedge clk_i);
        drive(1'b0, 5'd0, '0, 4'h0, 1'b0, 5'd0, 5'd7, 5'd7);
        #1;
        checks++; if (rBusy_o !== 2'b00) begin errors++; $display("FAIL busy_after: got %b expected 00", rBusy_o); end
        checks++; if (rD_o[31:0] !== 32'h0000_000D) begin errors++; $display("FAIL busy_data: got %h expected 0000000d", rD_o[31:0]); end
    endtask

    task automatic test_set_and_write();
        @(negedge clk_i);
        drive(1'b0, 5'd0, '0, 4'h0, 1'b1, 5'd9, 5'd9, 5'd9);
        step();
        @(negedge clk_i);
        drive(1'b1, 5'd9, 32'hCAFE_F00D, 4'hF, 1'b1, 5'd9, 5'd9, 5'd9);
        #1;
        checks++; if (rD_o[31:0] !== 32'hCAFE_F00D) begin errors++; $display("FAIL sw_bypass: got %h expected cafef00d", rD_o[31:0]); end
        checks++; if (rBusy_o !== 2'b11) begin errors++; $display("FAIL sw_busy_now: got %b expected 11", rBusy_o); end
        step();
        checks++; if (pend_cnt_o !== 6'd1) begin errors++; $display("FAIL sw_cnt: got %0d expected 1", pend_cnt_o); end
        @(negedge clk_i);
        drive(1'b0, 5'd0, '0, 4'h0, 1'b0, 5'd0, 5'd9, 5'd9);
        #1;
        checks++; if (rBusy_o !== 2'b11) begin errors++; $display("FAIL sw_busy_after: got %b expected 11", rBusy_o); end
        checks++; if (rD_o[63:32] !== 32'hCAFE_F00D) begin errors++; $display("FAIL sw_data: got %h expected cafef00d", rD_o[63:32]); end
    endtask

    task automatic test_random();
        logic [AW-1:0] a [2];
        logic [AW-1:0] wr, sr;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk_i);
            wr   = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            sr   = ($urandom_range(0, 2) == 0) ? wr : AW'($urandom_range(0, 7));
            a[0] = ($urandom_range(0, 2) == 0) ? wr : AW'($urandom_range(0, 7));
            a[1] = ($urandom_range(0, 3) == 0) ? a[0] : AW'($urandom);
            drive(1'($urandom_range(0, 1)), wr, $urandom, 4'($urandom),
                  ($urandom_range(0, 9) < 4), sr, a[0], a[1]);
            #1;
            for (int k = 0; k < NR; k++) begin
                checks++;
                if (rD_o[k*DW +: DW] !== exp_rd(int'(a[k]))) begin
                    errors++;
                    $display("FAIL rnd_rd%0d@%0d: got %h expected %h", k, n, rD_o[k*DW +: DW], exp_rd(int'(a[k])));
                end
                checks++;
                if (rBusy_o[k] !== exp_busy(int'(a[k]))) begin
                    errors++;
                    $display("FAIL rnd_busy%0d@%0d: got %b expected %b", k, n, rBusy_o[k], exp_busy(int'(a[k])));
                end
            end
            step();
            checks++;
            if (int'(pend_cnt_o) != exp_cnt()) begin
                errors++;
                $display("FAIL rnd_cnt@%0d: got %0d expected %0d", n, pend_cnt_o, exp_cnt());
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int r = 1; r < 32; r++) begin
            @(negedge clk_i);
            drive(1'b0, 5'd0, '0, 4'h0, 1'b1, AW'(r), 5'd3, 5'd4);
            step();
        end
        checks++; if (pend_cnt_o !== 6'd31) begin errors++; $display("FAIL full_cnt: got %0d expected 31", pend_cnt_o); end
        @(negedge clk_i);
        drive(1'b1, 5'd3, 32'h5555_5555, 4'hF, 1'b0, 5'd0, 5'd3, 5'd4);
        #2;
        reset_i = 1'b1;
        model_reset();
        #1;
        checks++; if (pend_cnt_o !== 6'd0) begin errors++; $display("FAIL mid_rst_cnt: got %0d expected 0", pend_cnt_o); end
        checks++; if (rD_o !== '0) begin errors++; $display("FAIL mid_rst_bypass: got %h expected 0", rD_o); end
        drive(1'b0, 5'd0, '0, 4'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        for (int r = 0; r < 32; r++) begin
            rR_i = {AW'(31 - r), AW'(r)};
            #1;
            checks++;
            if (rD_o !== '0 || rBusy_o !== '0) begin
                errors++;
                $display("FAIL mid_rst_rd%0d: got %h/%b expected 0/00", r, rD_o, rBusy_o);
            end
        end
        @(negedge clk_i);
        reset_i = 1'b0;
        drive(1'b0, 5'd0, '0, 4'h0, 1'b0, 5'd0, 5'd12, 5'd31);
        #1;
        checks++; if (rBusy_o !== 2'b00 || rD_o !== '0) begin errors++; $display("FAIL post_rst: got %h/%b expected 0/00", rD_o, rBusy_o); end
    endtask

    initial begin
        reset_i = 1'b1;
        drive(1'b0, 5'd0, '0, 4'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        model_reset();
        test_reset();
        test_write_read();
        test_byte_enable();
        test_r0();
        test_busy();
        test_set_and_write();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
